// File: rtl/wlb_pkg.sv
// Shared defaults and counter-width helpers for the sliding-window line buffer.
package wlb_pkg;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;
  localparam int DEF_WIN_W = 40;
  localparam int DEF_WIN_H = 100;
  localparam int DEF_PIX_W = 1;

  function automatic int col_width(input int img_w);
    return (img_w > 1) ? $clog2(img_w) : 1;
  endfunction

  function automatic int row_width(input int img_h);
    return (img_h > 1) ? $clog2(img_h) : 1;
  endfunction

endpackage

// File: rtl/window_linebuffer_line_store.sv
// One line of pixel history: synchronous write, asynchronous read at the same column.
module line_store
  import wlb_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [col_width(DEPTH)-1:0]   addr,
  input  logic [PIX_W-1:0]              wdata,
  output logic [PIX_W-1:0]              rdata
);

  logic [PIX_W-1:0] mem_r [DEPTH];

  // write port; contents are deliberately unreset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/window_linebuffer.sv
// Raster-scan sliding window generator: WIN_H-1 line stores feed a WIN_W x WIN_H shift window.
module window_linebuffer
  import wlb_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int WIN_W = DEF_WIN_W,
  parameter int WIN_H = DEF_WIN_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [PIX_W-1:0]               s_data,
  input  logic                           s_sof,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [WIN_W*WIN_H*PIX_W-1:0]   m_win,
  output logic [col_width(IMG_W)-1:0]    m_col,
  output logic [row_width(IMG_H)-1:0]    m_row,
  output logic                           m_eof
);

  localparam int COL_W    = col_width(IMG_W);
  localparam int ROW_W    = row_width(IMG_H);
  localparam int NLS      = WIN_H - 1;
  localparam int WIN_BITS = WIN_W * WIN_H * PIX_W;

  logic [COL_W-1:0]       col_r, cur_col_s, nxt_col_s;
  logic [ROW_W-1:0]       row_r, cur_row_s, nxt_row_s;
  logic                   accept_s, qualify_s, last_pix_s;
  logic [PIX_W-1:0]       ls_rd_s [NLS];
  logic [PIX_W-1:0]       ls_wd_s [NLS];
  logic [WIN_H*PIX_W-1:0] vcol_s;
  logic [WIN_BITS-1:0]    win_r, win_nxt_s;
  logic                   m_valid_r, m_eof_r;
  logic [COL_W-1:0]       m_col_r;
  logic [ROW_W-1:0]       m_row_r;

  assign s_ready  = !m_valid_r || m_ready;
  assign accept_s = s_valid && s_ready;

  // position of the pixel on s_data (sof forces origin) and the position after it
  always_comb begin
    cur_col_s = col_r;
    cur_row_s = row_r;
    if (s_sof) begin
      cur_col_s = {COL_W{1'b0}};
      cur_row_s = {ROW_W{1'b0}};
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
    end
    nxt_col_s = cur_col_s + COL_W'(1);
    nxt_row_s = cur_row_s;
    if (cur_col_s == COL_W'(IMG_W - 1)) begin
      nxt_col_s = {COL_W{1'b0}};
      if (cur_row_s == ROW_W'(IMG_H - 1)) begin
        nxt_row_s = {ROW_W{1'b0}};
      end else begin
        nxt_row_s = cur_row_s + ROW_W'(1);
      end
    end else begin
      nxt_row_s = cur_row_s;
    end
  end

  // a window is complete only once enough columns and lines of this frame exist
  assign qualify_s  = (cur_col_s >= COL_W'(WIN_W - 1)) && (cur_row_s >= ROW_W'(WIN_H - 1));
  assign last_pix_s = (cur_col_s == COL_W'(IMG_W - 1)) && (cur_row_s == ROW_W'(IMG_H - 1));

  // line k holds row-1-k; each accept pushes the column one line further into history
  for (genvar k = 0; k < NLS; k++) begin : g_ls
    line_store #(
      .DEPTH (IMG_W),
      .PIX_W (PIX_W)
    ) u_line_store (
      .clk   (clk),
      .we    (accept_s),
      .addr  (cur_col_s),
      .wdata (ls_wd_s[k]),
      .rdata (ls_rd_s[k])
    );
    if (k == 0) begin : g_head
      assign ls_wd_s[k] = s_data;
    end else begin : g_chain
      assign ls_wd_s[k] = ls_rd_s[k-1];
    end
    assign vcol_s[(NLS-1-k)*PIX_W +: PIX_W] = ls_rd_s[k];
  end
  assign vcol_s[NLS*PIX_W +: PIX_W] = s_data;

  // shift window one column left and append the fresh vertical column on the right
  always_comb begin
    win_nxt_s = win_r;
    for (int r = 0; r < WIN_H; r++) begin
      for (int c = 0; c < WIN_W - 1; c++) begin
        win_nxt_s[(r*WIN_W+c)*PIX_W +: PIX_W] = win_r[(r*WIN_W+c+1)*PIX_W +: PIX_W];
      end
      win_nxt_s[(r*WIN_W+WIN_W-1)*PIX_W +: PIX_W] = vcol_s[r*PIX_W +: PIX_W];
    end
  end

  // raster counters and window register advance on every accepted pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r <= {COL_W{1'b0}};
      row_r <= {ROW_W{1'b0}};
      win_r <= {WIN_BITS{1'b0}};
    end else if (accept_s) begin
      col_r <= nxt_col_s;
      row_r <= nxt_row_s;
      win_r <= win_nxt_s;
    end
  end

  // output handshake; window metadata only changes when a new window is loaded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_r <= 1'b0;
      m_col_r   <= {COL_W{1'b0}};
      m_row_r   <= {ROW_W{1'b0}};
      m_eof_r   <= 1'b0;
    end else if (accept_s && qualify_s) begin
      m_valid_r <= 1'b1;
      m_col_r   <= cur_col_s - COL_W'(WIN_W - 1);
      m_row_r   <= cur_row_s - ROW_W'(WIN_H - 1);
      m_eof_r   <= last_pix_s;
    end else if (m_ready) begin
      m_valid_r <= 1'b0;
      m_eof_r   <= 1'b0;
    end
  end

  assign m_valid = m_valid_r;
  assign m_win   = win_r;
  assign m_col   = m_col_r;
  assign m_row   = m_row_r;
  assign m_eof   = m_eof_r;

endmodule

// File: tb/tb_window_linebuffer.sv
// Scoreboard bench: two instances (1-bit and 8-bit pixels) share stimulus; a raster image model predicts windows.
module tb_window_linebuffer;

  localparam int IW   = 8;
  localparam int IH   = 6;
  localparam int WW   = 3;
  localparam int WH   = 2;
  localparam int NPIX = WW * WH;

  typedef struct packed {
    logic [NPIX*8-1:0] win;
    logic [2:0]        col;
    logic [2:0]        row;
    logic              eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_valid = 1'b0;
  logic s_sof = 1'b0;
  logic m_ready = 1'b0;
  logic [7:0] s_data = 8'd0;

  logic s_ready1, s_ready8, m_valid1, m_valid8, m_eof1, m_eof8;
  logic [NPIX-1:0]   m_win1;
  logic [NPIX*8-1:0] m_win8;
  logic [2:0] m_col1, m_col8, m_row1, m_row8;

  int compared = 0;
  int mismatched = 0;
  int acc_cnt = 0;
  int win_cnt = 0;
  int eof_cnt = 0;
  int mcol = 0;
  int mrow = 0;
  logic [2:0] eof_col, eof_row, first_col, first_row;
  logic [7:0] img [IH][IW];
  exp_t q[$];

  exp_t mon_e;
  logic mon_v, mon_rdy;
  logic [NPIX-1:0] mon_w1;
  int mc, mr;

  always #5 clk = ~clk;

  window_linebuffer #(.IMG_W(IW), .IMG_H(IH), .WIN_W(WW), .WIN_H(WH), .PIX_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data[0:0]),
    .s_sof(s_sof), .m_valid(m_valid1), .m_ready(m_ready), .m_win(m_win1),
    .m_col(m_col1), .m_row(m_row1), .m_eof(m_eof1)
  );

  window_linebuffer #(.IMG_W(IW), .IMG_H(IH), .WIN_W(WW), .WIN_H(WH), .PIX_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready8), .s_data(s_data),
    .s_sof(s_sof), .m_valid(m_valid8), .m_ready(m_ready), .m_win(m_win8),
    .m_col(m_col8), .m_row(m_row8), .m_eof(m_eof8)
  );

  // monitor: compare the head of the scoreboard, then feed the accepted pixel to the image model
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      q.delete();
      mcol = 0;
      mrow = 0;
    end else begin
      mon_v   = (q.size() != 0);
      mon_rdy = !mon_v || m_ready;
      compared++;
      if (m_valid1 !== mon_v || m_valid8 !== mon_v) begin
        mismatched++;
        $display("FAIL m_valid: got %b/%b expected %b at %0t", m_valid1, m_valid8, mon_v, $time);
      end
      compared++;
      if (s_ready1 !== mon_rdy || s_ready8 !== mon_rdy) begin
        mismatched++;
        $display("FAIL s_ready: got %b/%b expected %b at %0t", s_ready1, s_ready8, mon_rdy, $time);
      end
      if (mon_v) begin
        mon_e = q[0];
        for (int i = 0; i < NPIX; i++) mon_w1[i] = mon_e.win[i*8];
        compared++;
        if (m_win8 !== mon_e.win || m_win1 !== mon_w1) begin
          mismatched++;
          $display("FAIL m_win: got %h/%b expected %h/%b at %0t", m_win8, m_win1, mon_e.win, mon_w1, $time);
        end
        compared++;
        if (m_col8 !== mon_e.col || m_col1 !== mon_e.col || m_row8 !== mon_e.row || m_row1 !== mon_e.row) begin
          mismatched++;
          $display("FAIL m_pos: got col %0d/%0d row %0d/%0d expected col %0d row %0d at %0t",
                   m_col8, m_col1, m_row8, m_row1, mon_e.col, mon_e.row, $time);
        end
        compared++;
        if (m_eof8 !== mon_e.eof || m_eof1 !== mon_e.eof) begin
          mismatched++;
          $display("FAIL m_eof: got %b/%b expected %b at %0t", m_eof8, m_eof1, mon_e.eof, $time);
        end
        if (m_ready) begin
          if (win_cnt == 0) begin
            first_col = m_col8;
            first_row = m_row8;
          end
          win_cnt++;
          if (mon_e.eof) begin
            eof_cnt++;
            eof_col = m_col8;
            eof_row = m_row8;
          end
          void'(q.pop_front());
        end
      end
      if (s_valid && mon_rdy) begin
        if (s_sof) begin
          mc = 0;
          mr = 0;
        end else begin
          mc = mcol;
          mr = mrow;
        end
        img[mr][mc] = s_data;
        acc_cnt++;
        if (mc >= WW - 1 && mr >= WH - 1) begin
          for (int wr = 0; wr < WH; wr++)
            for (int wc = 0; wc < WW; wc++)
              mon_e.win[(wr*WW+wc)*8 +: 8] = img[mr-(WH-1)+wr][mc-(WW-1)+wc];
          mon_e.col = 3'(mc - (WW - 1));
          mon_e.row = 3'(mr - (WH - 1));
          mon_e.eof = (mc == IW - 1) && (mr == IH - 1);
          q.push_back(mon_e);
        end
        if (mc == IW - 1) begin
          mcol = 0;
          mrow = (mr == IH - 1) ? 0 : mr + 1;
        end else begin
          mcol = mc + 1;
          mrow = mr;
        end
      end
    end
  end

  // called at a negedge; returns at a negedge after n pixels have been accepted
  task automatic drive_pixels(input int n, input bit rnd_data, input bit sof_first,
                              input int pv, input int pr, input bit hold_first);
    int target = acc_cnt + n;
    int start  = acc_cnt;
    int guard  = 0;
    int held   = 0;
    bit seen   = 1'b0;
    logic [NPIX*8-1:0] cap_win;
    logic [2:0] cap_col, cap_row;
    while (acc_cnt < target && guard < 5000) begin
      if (hold_first && !seen && q.size() != 0) begin
        seen = 1'b1;
        held = 5;
        cap_win = m_win8;
        cap_col = m_col8;
        cap_row = m_row8;
      end
      s_sof   = sof_first && (acc_cnt == start);
      s_valid = ($urandom_range(99) < pv);
      if (rnd_data) s_data = 8'($urandom_range(255));
      else          s_data = s_sof ? 8'd0 : 8'((mcol + mrow) % 2);
      if (held > 0) begin
        m_ready = 1'b0;
        #3;
        compared++;
        if (s_ready8 !== 1'b0 || s_ready1 !== 1'b0 || m_win8 !== cap_win || m_col8 !== cap_col || m_row8 !== cap_row) begin
          mismatched++;
          $display("FAIL hold: s_ready %b win %h col %0d row %0d expected 0 %h %0d %0d",
                   s_ready8, m_win8, m_col8, m_row8, cap_win, cap_col, cap_row);
        end
        held--;
      end else begin
        m_ready = ($urandom_range(99) < pr);
      end
      @(negedge clk);
      guard++;
    end
    if (acc_cnt < target) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: accepted %0d of %0d pixels", acc_cnt - start, n);
    end
  endtask

  task automatic drain();
    s_valid = 1'b0;
    s_sof   = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    compared++;
    if (m_valid1 !== 1'b0 || m_valid8 !== 1'b0 || m_win1 !== '0 || m_win8 !== '0 ||
        m_col8 !== 3'd0 || m_row8 !== 3'd0 || m_eof8 !== 1'b0 || s_ready1 !== 1'b1 || s_ready8 !== 1'b1) begin
      mismatched++;
      $display("FAIL reset: valid %b win %h col %0d row %0d eof %b ready %b", m_valid8, m_win8, m_col8, m_row8, m_eof8, s_ready8);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame();
    win_cnt = 0;
    eof_cnt = 0;
    drive_pixels(IW*IH, 1'b0, 1'b1, 100, 100, 1'b0);
    drain();
    compared++;
    if (win_cnt !== 30 || eof_cnt !== 1) begin
      mismatched++;
      $display("FAIL frame_count: windows %0d eofs %0d expected 30 1", win_cnt, eof_cnt);
    end
    compared++;
    if (first_col !== 3'd0 || first_row !== 3'd0 || eof_col !== 3'd5 || eof_row !== 3'd4) begin
      mismatched++;
      $display("FAIL frame_pos: first (%0d,%0d) eof (%0d,%0d) expected (0,0) (5,4)", first_col, first_row, eof_col, eof_row);
    end
  endtask

  task automatic test_backpressure();
    win_cnt = 0;
    drive_pixels(IW*IH, 1'b0, 1'b1, 100, 100, 1'b1);
    drain();
    compared++;
    if (win_cnt !== 30) begin
      mismatched++;
      $display("FAIL backpressure_count: windows %0d expected 30", win_cnt);
    end
  endtask

  task automatic test_sof_restart();
    drive_pixels(2*IW + 3, 1'b0, 1'b1, 100, 100, 1'b0);
    drain();
    win_cnt = 0;
    drive_pixels(IW*IH, 1'b0, 1'b1, 100, 100, 1'b0);
    drain();
    compared++;
    if (win_cnt !== 30 || first_col !== 3'd0 || first_row !== 3'd0) begin
      mismatched++;
      $display("FAIL sof_restart: windows %0d first (%0d,%0d) expected 30 (0,0)", win_cnt, first_col, first_row);
    end
  endtask

  task automatic test_reset_mid();
    drive_pixels(2*IW + 4, 1'b1, 1'b1, 100, 100, 1'b0);
    rst = 1'b0;
    s_valid = 1'b0;
    #1;
    compared++;
    if (m_valid8 !== 1'b0 || m_valid1 !== 1'b0 || m_win8 !== '0 || m_win1 !== '0 ||
        m_col8 !== 3'd0 || m_row8 !== 3'd0 || m_eof8 !== 1'b0 || s_ready8 !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid: valid %b win %h col %0d row %0d eof %b ready %b", m_valid8, m_win8, m_col8, m_row8, m_eof8, s_ready8);
    end
    @(negedge clk);
    rst = 1'b1;
    win_cnt = 0;
    drive_pixels(IW*IH, 1'b1, 1'b0, 100, 100, 1'b0);
    drain();
    compared++;
    if (win_cnt !== 30 || first_col !== 3'd0 || first_row !== 3'd0) begin
      mismatched++;
      $display("FAIL reset_mid_frame: windows %0d first (%0d,%0d) expected 30 (0,0)", win_cnt, first_col, first_row);
    end
  endtask

  task automatic test_random();
    win_cnt = 0;
    eof_cnt = 0;
    for (int f = 0; f < 3; f++) drive_pixels(IW*IH, 1'b1, 1'b1, 70, 60, 1'b0);
    drain();
    compared++;
    if (win_cnt !== 90 || eof_cnt !== 3) begin
      mismatched++;
      $display("FAIL random_count: windows %0d eofs %0d expected 90 3", win_cnt, eof_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_sof_restart();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
